// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Program-counter / instruction-fetch stage. Owns the PC and drives the word
//   address and select of a combinational instruction ROM. The returned word is
//   registered into the IF/ID latch for decode. The stage handles stall,
//   branch/jump redirect, halt (syscall exit) and the text-segment window.
//
// Parameters
//   ROM_ADDR_BITS  ROM word-address width (depth = 2**ROM_ADDR_BITS words)
//   TEXT_BASE      byte address of ROM word 0; also the reset PC
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold PC and IF/ID latch
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    byte target of the redirect
//   halt           stop fetching; only rst_n leaves HALT
//   rom_addr       word address to ROM (decode of pc/state)
//   rom_sel        ROM select (decode of state)
//   rom_dout       ROM data, valid in the same cycle as rom_addr
//   if_valid       IF/ID latch holds a real instruction
//   if_pc          byte PC of if_instr
//   if_instr       fetched instruction
//   fetch_err      sticky: PC left the text window or redirect was misaligned
//   inst_count     number of instructions delivered into the latch
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          ROM_ADDR_BITS = 10,
    parameter logic [31:0] TEXT_BASE     = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    output logic                     rom_sel,
    input  logic [31:0]              rom_dout,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic                     fetch_err,
    output logic [31:0]              inst_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // The PC is always word aligned (redirect targets are forced to 00), so
    // only the upper 30 bits are stored. Wrap at 2**30 words equals the byte
    // PC wrapping at 2**32.
    localparam logic [29:0] BASE_WORD = TEXT_BASE[31:2];

    logic [1:0]  state_r;
    logic [29:0] pc_word_r;
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        fetch_err_r;
    logic [31:0] inst_count_r;

    logic [1:0]  state_nx_s;
    logic [29:0] pc_word_nx_s;
    logic        if_valid_nx_s;
    logic [31:0] if_pc_nx_s;
    logic [31:0] if_instr_nx_s;
    logic        fetch_err_nx_s;
    logic [31:0] inst_count_nx_s;

    logic [29:0] word_off_s;
    logic        out_of_window_s;
    logic        misaligned_s;

    // Window decode: offset from the base computed in words; anything above
    // the ROM depth or below the base is outside the text segment.
    always_comb begin
        word_off_s      = pc_word_r - BASE_WORD;
        out_of_window_s = (pc_word_r < BASE_WORD) ||
                          (word_off_s[29:ROM_ADDR_BITS] != {(30-ROM_ADDR_BITS){1'b0}});
        misaligned_s    = (redirect_pc[1:0] != 2'b00);
    end

    // ROM interface is a pure decode of the state and PC registers.
    always_comb begin
        if (state_r == ST_RUN) begin
            rom_sel  = 1'b1;
            rom_addr = word_off_s[ROM_ADDR_BITS-1:0];
        end else begin
            rom_sel  = 1'b0;
            rom_addr = {ROM_ADDR_BITS{1'b0}};
        end
    end

    // Next-state logic; in RUN the priority is halt > redirect > stall > fetch.
    always_comb begin
        state_nx_s      = state_r;
        pc_word_nx_s    = pc_word_r;
        if_valid_nx_s   = if_valid_r;
        if_pc_nx_s      = if_pc_r;
        if_instr_nx_s   = if_instr_r;
        fetch_err_nx_s  = fetch_err_r;
        inst_count_nx_s = inst_count_r;
        case (state_r)
            ST_BOOT: begin
                state_nx_s = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_nx_s    = ST_HALT;
                    if_valid_nx_s = 1'b0;
                end else if (redirect_valid) begin
                    // Word fetched this cycle is on the wrong path: discard it.
                    pc_word_nx_s   = redirect_pc[31:2];
                    if_valid_nx_s  = 1'b0;
                    fetch_err_nx_s = fetch_err_r | misaligned_s | out_of_window_s;
                end else if (stall) begin
                    fetch_err_nx_s = fetch_err_r | out_of_window_s;
                end else begin
                    if_pc_nx_s      = {pc_word_r, 2'b00};
                    // Outside the window a NOP is delivered instead of ROM data.
                    if_instr_nx_s   = out_of_window_s ? 32'h0000_0000 : rom_dout;
                    if_valid_nx_s   = 1'b1;
                    pc_word_nx_s    = pc_word_r + 30'd1;
                    inst_count_nx_s = inst_count_r + 32'd1;
                    fetch_err_nx_s  = fetch_err_r | out_of_window_s;
                end
            end
            ST_HALT: begin
                if_valid_nx_s = 1'b0;
            end
            default: begin
                // Unreachable encoding: restart cleanly through BOOT.
                state_nx_s    = ST_BOOT;
                if_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State and IF/ID latch registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            pc_word_r    <= BASE_WORD;
            if_valid_r   <= 1'b0;
            if_pc_r      <= 32'h0000_0000;
            if_instr_r   <= 32'h0000_0000;
            fetch_err_r  <= 1'b0;
            inst_count_r <= 32'h0000_0000;
        end else begin
            state_r      <= state_nx_s;
            pc_word_r    <= pc_word_nx_s;
            if_valid_r   <= if_valid_nx_s;
            if_pc_r      <= if_pc_nx_s;
            if_instr_r   <= if_instr_nx_s;
            fetch_err_r  <= fetch_err_nx_s;
            inst_count_r <= inst_count_nx_s;
        end
    end

    assign if_valid   = if_valid_r;
    assign if_pc      = if_pc_r;
    assign if_instr   = if_instr_r;
    assign fetch_err  = fetch_err_r;
    assign inst_count = inst_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Bench for instr_fetch. A large instance (ROM_ADDR_BITS=10) is driven by a
//   directed vector table, hand sequences and random stimulus checked against
//   a behavioural model. A small instance (ROM_ADDR_BITS=4) is used to run off
//   the end of the text window.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [9:0]  rom_addr;
    logic        rom_sel;
    logic [31:0] rom_dout;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_err;
    logic [31:0] inst_count;

    logic        s_stall;
    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_halt;
    logic [3:0]  s_rom_addr;
    logic        s_rom_sel;
    logic [31:0] s_rom_dout;
    logic        s_if_valid;
    logic [31:0] s_if_pc;
    logic [31:0] s_if_instr;
    logic        s_fetch_err;
    logic [31:0] s_inst_count;

    int n_checks = 0;
    int n_errors = 0;

    // ROM contents: a scrambled function of the word address, never zero at 0.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_dout   = rom_fn({22'd0, rom_addr});
    assign s_rom_dout = rom_fn({28'd0, s_rom_addr});

    instr_fetch #(.ROM_ADDR_BITS(10), .TEXT_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .rom_dout(rom_dout), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .fetch_err(fetch_err), .inst_count(inst_count)
    );

    instr_fetch #(.ROM_ADDR_BITS(4), .TEXT_BASE(BASE)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(s_stall), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .halt(s_halt), .rom_addr(s_rom_addr), .rom_sel(s_rom_sel),
        .rom_dout(s_rom_dout), .if_valid(s_if_valid), .if_pc(s_if_pc), .if_instr(s_if_instr),
        .fetch_err(s_fetch_err), .inst_count(s_inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit          m_boot;
    bit          m_halted;
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_err;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_boot = 1'b1; m_halted = 1'b0; m_pc = BASE;
        m_v = 1'b0; m_ipc = 32'd0; m_instr = 32'd0; m_err = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic model_edge(input logic st, input logic rv, input logic [31:0] rp, input logic h);
        longint lo, hi, p;
        bit     bad;
        lo  = longint'(BASE);
        hi  = lo + 4 * 1024;
        p   = longint'({32'd0, m_pc});
        bad = (p < lo) || (p >= hi);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted) begin
            if (h) begin
                m_halted = 1'b1; m_v = 1'b0;
            end else if (rv) begin
                if (rp[1:0] != 2'b00 || bad) m_err = 1'b1;
                m_pc = {rp[31:2], 2'b00};
                m_v  = 1'b0;
            end else if (st) begin
                if (bad) m_err = 1'b1;
            end else begin
                m_ipc   = m_pc;
                m_instr = bad ? 32'd0 : rom_fn(((m_pc - BASE) >> 2) & 32'h3FF);
                m_v     = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_cnt   = m_cnt + 32'd1;
                if (bad) m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] model_addr();
        if (!m_boot && !m_halted) return ((m_pc - BASE) >> 2) & 32'h3FF;
        return 32'd0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".if_valid"},   {31'd0, if_valid},  {31'd0, m_v});
        chk({tag, ".if_pc"},      if_pc,              m_ipc);
        chk({tag, ".if_instr"},   if_instr,           m_instr);
        chk({tag, ".fetch_err"},  {31'd0, fetch_err}, {31'd0, m_err});
        chk({tag, ".inst_count"}, inst_count,         m_cnt);
        chk({tag, ".rom_sel"},    {31'd0, rom_sel},   {31'd0, (!m_boot && !m_halted)});
        chk({tag, ".rom_addr"},   {22'd0, rom_addr},  model_addr());
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rp, input logic h);
        stall = st; redirect_valid = rv; redirect_pc = rp; halt = h;
        @(posedge clk);
        model_edge(st, rv, rp, h);
        #1;
    endtask

    task automatic do_reset(input bit check_it);
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        if (check_it) check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rp;
        logic        h;
        logic        ev;
        logic [31:0] eipc;
        logic [31:0] einstr;
        logic [31:0] ecnt;
        logic        eerr;
        logic        esel;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic rv, input logic [31:0] rp, input logic h,
                       input logic ev, input logic [31:0] eipc, input logic [31:0] einstr,
                       input logic [31:0] ecnt, input logic eerr, input logic esel,
                       input logic [31:0] eaddr);
        vec_t v;
        v.st = st; v.rv = rv; v.rp = rp; v.h = h; v.ev = ev; v.eipc = eipc;
        v.einstr = einstr; v.ecnt = ecnt; v.eerr = eerr; v.esel = esel; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    initial begin
        int halted_cycles;
        logic [31:0] rp;
        logic st, rv, h;

        s_stall = 1'b0; s_redirect_valid = 1'b0; s_redirect_pc = 32'd0; s_halt = 1'b0;
        rst_n = 1'b1;

        //   st rv  rp            h   v   if_pc         instr       cnt  err sel addr
        add(0, 0, 32'h0,        0,  0, 32'h0,      32'h0,      0,   0,  1,  0);  // BOOT edge
        add(0, 0, 32'h0,        0,  1, 32'h3000,   rom_fn(0),  1,   0,  1,  1);
        add(0, 0, 32'h0,        0,  1, 32'h3004,   rom_fn(1),  2,   0,  1,  2);
        add(1, 0, 32'h0,        0,  1, 32'h3004,   rom_fn(1),  2,   0,  1,  2);  // stall
        add(1, 0, 32'h0,        0,  1, 32'h3004,   rom_fn(1),  2,   0,  1,  2);  // stall
        add(0, 0, 32'h0,        0,  1, 32'h3008,   rom_fn(2),  3,   0,  1,  3);
        add(0, 0, 32'h0,        0,  1, 32'h300C,   rom_fn(3),  4,   0,  1,  4);
        add(1, 1, 32'h3040,     0,  0, 32'h300C,   rom_fn(3),  4,   0,  1, 16);  // redirect over stall
        add(0, 0, 32'h0,        0,  1, 32'h3040,   rom_fn(16), 5,   0,  1, 17);
        add(0, 1, 32'h3042,     0,  0, 32'h3040,   rom_fn(16), 5,   1,  1, 16);  // misaligned
        add(0, 0, 32'h0,        0,  1, 32'h3040,   rom_fn(16), 6,   1,  1, 17);
        add(0, 1, 32'h3100,     1,  0, 32'h3040,   rom_fn(16), 6,   1,  0,  0);  // halt wins
        for (int i = 0; i < 10; i++)
            add(i[0], 1, 32'h3200, ~i[0], 0, 32'h3040, rom_fn(16), 6, 1, 0, 0);

        do_reset(1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            stall = tbl[i].st; redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rp; halt = tbl[i].h;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.if_valid", i),   {31'd0, if_valid},  {31'd0, tbl[i].ev});
            chk($sformatf("v%0d.if_pc", i),      if_pc,              tbl[i].eipc);
            chk($sformatf("v%0d.if_instr", i),   if_instr,           tbl[i].einstr);
            chk($sformatf("v%0d.inst_count", i), inst_count,         tbl[i].ecnt);
            chk($sformatf("v%0d.fetch_err", i),  {31'd0, fetch_err}, {31'd0, tbl[i].eerr});
            chk($sformatf("v%0d.rom_sel", i),    {31'd0, rom_sel},   {31'd0, tbl[i].esel});
            chk($sformatf("v%0d.rom_addr", i),   {22'd0, rom_addr},  tbl[i].eaddr);
        end

        // Reset pulse out of HALT restarts at the text base.
        do_reset(1'b0);
        step(0, 0, 32'd0, 0);
        step(0, 0, 32'd0, 0);
        chk("restart.if_pc", if_pc, 32'h0000_3000);
        chk("restart.if_valid", {31'd0, if_valid}, 32'd1);

        // Small ROM: run past the last word of the window.
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) step(0, 0, 32'd0, 0);
        chk("small.last_pc",    s_if_pc, 32'h0000_303C);
        chk("small.last_instr", s_if_instr, rom_fn(32'd15));
        chk("small.err_before", {31'd0, s_fetch_err}, 32'd0);
        step(0, 0, 32'd0, 0);
        chk("small.oow_pc",    s_if_pc, 32'h0000_3040);
        chk("small.oow_instr", s_if_instr, 32'h0000_0000);
        chk("small.oow_err",   {31'd0, s_fetch_err}, 32'd1);
        chk("small.oow_valid", {31'd0, s_if_valid}, 32'd1);
        chk("small.oow_count", s_inst_count, 32'd17);
        check_model("small.main");

        // Asynchronous reset in the middle of a cycle.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 32'd0, 0);
        chk("async.pre_count", inst_count, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.if_valid",   {31'd0, if_valid},  32'd0);
        chk("async.if_pc",      if_pc,              32'd0);
        chk("async.inst_count", inst_count,         32'd0);
        chk("async.rom_sel",    {31'd0, rom_sel},   32'd0);
        chk("async.s_count",    s_inst_count,       32'd0);

        // Random stimulus against the reference model.
        do_reset(1'b1);
        halted_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            h  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0:       rp = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
                1:       rp = BASE - 32'(4 * $urandom_range(1, 8));
                2:       rp = BASE + 32'h0000_1000 + 32'(4 * $urandom_range(0, 8));
                default: rp = BASE + 32'(4 * $urandom_range(0, 1023));
            endcase
            step(st, rv, rp, h);
            check_model($sformatf("rnd%0d", i));
            if (m_halted) halted_cycles++;
            if (halted_cycles > 6) begin
                halted_cycles = 0;
                do_reset(1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
